// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: bus widths, bus layouts, load encodings and FSM states.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 113;
    localparam int MS_TO_WS_BUS_WD = 76;

    typedef enum logic [2:0] {
        LT_LW  = 3'd0,
        LT_LB  = 3'd1,
        LT_LBU = 3'd2,
        LT_LH  = 3'd3,
        LT_LHU = 3'd4,
        LT_LWL = 3'd5,
        LT_LWR = 3'd6
    } load_type_e;

    typedef enum logic [1:0] {
        MS_IDLE    = 2'd0,
        MS_WAIT    = 2'd1,
        MS_HOLD    = 2'd2,
        MS_DISCARD = 2'd3
    } ms_state_e;

    typedef struct packed {
        logic        mem_req;
        logic        ex;
        logic [4:0]  excode;
        logic [2:0]  load_type;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] rt_value;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage

// File: rtl/mem_stage_if.sv
// Pipeline link between two stages. A transfer happens on every clock edge where
// valid & allowin are both high; bus is meaningful only while valid is high.
interface mem_stage_if #(parameter int WD = 32);
    logic          valid;
    logic          allowin;
    logic [WD-1:0] bus;

    modport master (output valid, output bus, input allowin);
    modport slave  (input valid, input bus, output allowin);
endinterface

// File: rtl/mem_stage_load_align.sv
// Combinational load data alignment and extension, including the LWL/LWR merge with rt.
module load_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  load_type,
    input  logic [1:0]  addr,
    input  logic [31:0] rdata,
    input  logic [31:0] rt_value,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr, 3'b000} +: 8];
    assign half_sel = addr[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        result = rdata;
        case (load_type)
            LT_LB:  result = {{24{byte_sel[7]}}, byte_sel};
            LT_LBU: result = {24'h0, byte_sel};
            LT_LH:  result = {{16{half_sel[15]}}, half_sel};
            LT_LHU: result = {16'h0, half_sel};
            // Unaligned word loads keep the rt bytes the memory word does not cover.
            LT_LWL: begin
                case (addr)
                    2'd0:    result = {rdata[7:0],  rt_value[23:0]};
                    2'd1:    result = {rdata[15:0], rt_value[15:0]};
                    2'd2:    result = {rdata[23:0], rt_value[7:0]};
                    default: result = rdata;
                endcase
            end
            LT_LWR: begin
                case (addr)
                    2'd0:    result = rdata;
                    2'd1:    result = {rt_value[31:24], rdata[31:8]};
                    2'd2:    result = {rt_value[31:16], rdata[31:16]};
                    default: result = {rt_value[31:8],  rdata[31:24]};
                endcase
            end
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: waits for the data-SRAM response, aligns load data and feeds WB,
// forwarding and the exception-in-flight flag to the earlier stages.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.slave  es_ms,
    mem_stage_if.master ms_ws,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    output logic        ms_fwd_valid,
    output logic [4:0]  ms_fwd_dest,
    output logic [31:0] ms_fwd_data,
    output logic        ms_fwd_ready,
    output logic        ms_ex_out,
    input  logic        flush,
    output ms_state_e   ms_state_dbg
);

    ms_state_e   state_q;
    logic        ms_valid;
    es_to_ms_t   bus_q;
    logic [31:0] rdata_buf;

    es_to_ms_t   es_bus;
    ms_to_ws_t   out_bus;
    logic        ws_allowin;
    logic        ms_ready_go;
    logic        ms_allowin;
    logic [31:0] load_data;
    logic [31:0] aligned;
    logic [31:0] final_result;

    assign es_bus     = es_ms.bus;
    assign ws_allowin = ms_ws.allowin;

    assign ms_ready_go = !bus_q.mem_req
                       | (state_q == MS_WAIT && data_sram_data_ok)
                       | (state_q == MS_HOLD);
    // A squashed request still owes its data_ok, so nothing new may enter until it arrives.
    assign ms_allowin  = (state_q != MS_DISCARD) && (!ms_valid || (ms_ready_go && ws_allowin));
    assign es_ms.allowin = ms_allowin;

    assign load_data = (state_q == MS_HOLD) ? rdata_buf : data_sram_rdata;

    load_align u_load_align (
        .load_type (bus_q.load_type),
        .addr      (bus_q.alu_result[1:0]),
        .rdata     (load_data),
        .rt_value  (bus_q.rt_value),
        .result    (aligned)
    );

    assign final_result = bus_q.res_from_mem ? aligned : bus_q.alu_result;

    assign out_bus.ex           = bus_q.ex;
    assign out_bus.excode       = bus_q.excode;
    assign out_bus.gr_we        = bus_q.gr_we;
    assign out_bus.dest         = bus_q.dest;
    assign out_bus.final_result = final_result;
    assign out_bus.pc           = bus_q.pc;

    assign ms_ws.valid = ms_valid && ms_ready_go && !flush;
    assign ms_ws.bus   = out_bus;

    assign ms_fwd_valid = ms_valid && bus_q.gr_we;
    assign ms_fwd_dest  = bus_q.dest;
    assign ms_fwd_data  = final_result;
    assign ms_fwd_ready = !bus_q.res_from_mem || ms_ready_go;
    assign ms_ex_out    = ms_valid && bus_q.ex;
    assign ms_state_dbg = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= MS_IDLE;
            ms_valid  <= 1'b0;
            bus_q     <= '0;
            rdata_buf <= '0;
        end else if (flush) begin
            ms_valid <= 1'b0;
            if ((state_q == MS_WAIT || state_q == MS_DISCARD) && !data_sram_data_ok)
                state_q <= MS_DISCARD;
            else
                state_q <= MS_IDLE;
        end else begin
            case (state_q)
                MS_WAIT: begin
                    if (data_sram_data_ok) begin
                        if (ws_allowin) begin
                            state_q <= MS_IDLE;
                        end else begin
                            state_q   <= MS_HOLD;
                            rdata_buf <= data_sram_rdata;
                        end
                    end
                end
                MS_HOLD:    if (ws_allowin) state_q <= MS_IDLE;
                MS_DISCARD: if (data_sram_data_ok) state_q <= MS_IDLE;
                default:    state_q <= state_q;
            endcase
            if (ms_allowin)
                ms_valid <= es_ms.valid;
            // A new arrival overrides the retirement transition taken above.
            if (es_ms.valid && ms_allowin) begin
                bus_q   <= es_bus;
                state_q <= es_bus.mem_req ? MS_WAIT : MS_IDLE;
            end
        end
    end

endmodule
